// File: rtl/vs_pkg.sv
// Shared definitions for the valid/stall arbiter: index-width helper, counter width,
// and the output-register state type.
package vs_pkg;

  localparam int VS_CNT_W = 16;

  typedef logic [VS_CNT_W-1:0] vs_cnt_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N.
module rr_pick
  import vs_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] w,
  output logic [N-1:0]  gnt
);

  logic [SW-1:0] idx;

  always_comb begin
    any = 1'b0;
    w   = '0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = SW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        w        = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vs_rr_arb.sv
// N-to-1 round-robin arbiter with a registered valid/stall output stage.
// Optional per-requester accept counters are built when VS_ARB_STATS_EN is defined.
module vs_rr_arb
  import vs_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WIDTH = 32,
  localparam int SW    = clog2_min1(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            valid_us,
  input  logic [N-1:0][WIDTH-1:0] data_us,
  output logic [N-1:0]            stall_us,
  output logic                    valid_ds,
  output logic [WIDTH-1:0]        data_ds,
  output logic [SW-1:0]           src_ds,
  input  logic                    stall_ds
`ifdef VS_ARB_STATS_EN
  ,
  output vs_cnt_t [N-1:0]         acc_cnt
`endif
);

  // state     | meaning
  // OUT_EMPTY | no beat held, valid_ds low
  // OUT_FULL  | beat held in data_ds/src_ds, waiting for !stall_ds
  out_state_e    state;
  logic [SW-1:0] ptr;
  logic          any;
  logic [SW-1:0] w;
  logic [N-1:0]  gnt;
  logic          adv;

  rr_pick #(.N(N)) u_pick (
    .req (valid_us),
    .ptr (ptr),
    .any (any),
    .w   (w),
    .gnt (gnt)
  );

  assign valid_ds = (state == OUT_FULL);
  assign adv      = !valid_ds || !stall_ds;
  assign stall_us = valid_us & ~({N{adv}} & gnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OUT_EMPTY;
      data_ds <= '0;
      src_ds  <= '0;
      ptr     <= '0;
    end else if (adv) begin
      if (any) begin
        state   <= OUT_FULL;
        data_ds <= data_us[w];
        src_ds  <= w;
        ptr     <= (w == SW'(N-1)) ? '0 : w + 1'b1;
      end else begin
        state <= OUT_EMPTY;
      end
    end
  end

`ifdef VS_ARB_STATS_EN
  // An accept is exactly a grant on an advancing cycle; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (adv && gnt[i] && (acc_cnt[i] != '1))
          acc_cnt[i] <= acc_cnt[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vs_rr_arb.sv
// Self-checking bench for vs_rr_arb (N=4, WIDTH=32) against a transaction-level model.
module tb_vs_rr_arb;

  localparam int N  = 4;
  localparam int WD = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       valid_us;
  logic [N-1:0][WD-1:0] data_us;
  logic [N-1:0]       stall_us;
  logic               valid_ds;
  logic [WD-1:0]      data_ds;
  logic [1:0]         src_ds;
  logic               stall_ds;
`ifdef VS_ARB_STATS_EN
  logic [N-1:0][15:0] acc_cnt;
`endif

  vs_rr_arb #(.N(N), .WIDTH(WD)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_us (valid_us),
    .data_us  (data_us),
    .stall_us (stall_us),
    .valid_ds (valid_ds),
    .data_ds  (data_ds),
    .src_ds   (src_ds),
    .stall_ds (stall_ds)
`ifdef VS_ARB_STATS_EN
    ,
    .acc_cnt  (acc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the downstream port should show, plus fairness pointer and accept tallies.
  bit          m_valid;
  bit [31:0]   m_data;
  int          m_src;
  int          m_ptr;
  int          m_acc [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_acc[i] = 0;
  endtask

  task automatic check_out(input string tag);
    check({tag, "_valid"}, {31'b0, valid_ds}, {31'b0, m_valid});
    check({tag, "_data"},  data_ds, m_data);
    check({tag, "_src"},   {30'b0, src_ds}, m_src);
  endtask

  // One clock: drive inputs just after a falling edge, check stalls, then outputs after the next fall.
  task automatic step(input logic [N-1:0] vus, input bit stl, input bit rnd_data, input string tag);
    int     win;
    bit     adv;
    logic [N-1:0] exp_stall;
    valid_us = vus;
    stall_ds = stl;
    if (rnd_data) for (int i = 0; i < N; i++) data_us[i] = $urandom;
    #1;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && vus[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    adv = !m_valid || !stl;
    for (int i = 0; i < N; i++) exp_stall[i] = vus[i] && !(adv && win == i);
    check({tag, "_stall_us"}, {28'b0, stall_us}, {28'b0, exp_stall});
    @(posedge clk);
    if (adv) begin
      if (win >= 0) begin
        m_valid = 1;
        m_data  = data_us[win];
        m_src   = win;
        m_ptr   = (win + 1) % N;
        if (m_acc[win] < 65535) m_acc[win]++;
      end else begin
        m_valid = 0;
      end
    end
    @(negedge clk);
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1;
    valid_us = '0;
    data_us = '0;
    stall_ds = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_out("reset");
    rst = 1'b0;

    // Saturating request pattern rotates 0,1,2,3,...
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 0, 1, "t1");
      check("t1_seq", {30'b0, src_ds}, i % 4);
    end

    // Two requesters alternate; the loser is stalled each cycle.
    for (int i = 0; i < 4; i++) begin
      step(4'b1010, 0, 1, "t2");
      check("t2_seq", {30'b0, src_ds}, (i % 2) ? 3 : 1);
    end

    // Grant on 2, then hold under downstream stall.
    data_us = '0;
    data_us[2] = 32'hA5;
    step(4'b0100, 0, 0, "t3g");
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1, 1, "t3s");
      check("t3_hold_data", data_ds, 32'hA5);
      check("t3_hold_src", {30'b0, src_ds}, 2);
      check("t3_all_stall", {28'b0, stall_us}, 4'b1111);
    end
    step(4'b1111, 0, 1, "t3r");
    check("t3_next", {30'b0, src_ds}, 3);

    // Pointer wrap 3 -> 0 with single requesters.
    step(4'b1000, 0, 1, "t4a");
    check("t4_src3", {30'b0, src_ds}, 3);
    step(4'b0001, 0, 1, "t4b");
    check("t4_src0", {30'b0, src_ds}, 0);
    check("t4_valid", {31'b0, valid_ds}, 1);

    // Random traffic and backpressure.
    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1, "rnd");

    // Asynchronous reset while a beat is held under stall.
    step(4'b0110, 0, 1, "t5a");
    step(4'b1111, 1, 1, "t5b");
    check("t5_pre_valid", {31'b0, valid_ds}, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_out("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    step(4'b1010, 0, 1, "t5c");
    check("t5_first", {30'b0, src_ds}, 1);

`ifdef VS_ARB_STATS_EN
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step(4'b0010, 0, 1, "t6");
    for (int i = 0; i < N; i++) check("t6_cnt", acc_cnt[i], (i == 1) ? 100 : 0);
    for (int i = 0; i < 69900; i++) begin
      valid_us = 4'b0010;
      stall_ds = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) check("t6_sat", acc_cnt[i], (i == 1) ? 16'hFFFF : 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
